uart_rx_vote_sampler: RTL and testbench
=======================================

Name: uart_rx_vote_sampler

Overview:
Parametrised oversampling data sampler for the UART receiver. It captures a configurable odd number of RX_IN samples in a window centred on the middle of the bit period. Each sample is taken when edge_cnt hits the matching offset. The block then outputs a registered majority-vote bit, a one-cycle valid strobe and a noise flag. It sits between the RX edge/bit counter and the RX FSM/deserializer and is configured by the same Prescale bus.

Parameters:
PRESCALE_W, 6, width of Prescale and edge_cnt.
MAX_SAMPLES, 5, largest supported sample count; must be odd and >= 1.
SYNC_STAGES, 0, flops on RX_IN before sampling; 0 means RX_IN is sampled directly.
CNT_W, clog2(MAX_SAMPLES+1), width of samp_num (derived, not overridden).

Ports:
CLK  in  1  system clock (RX clock domain).
RST  in  1  asynchronous, active-low reset.
data_samp_en  in  1  sampling enable from RX FSM.
RX_IN  in  1  serial line.
edge_cnt  in  PRESCALE_W  oversampling edge counter, 0..Prescale-1.
Prescale  in  PRESCALE_W  oversampling ratio.
samp_num  in  CNT_W  number of samples per bit.
sampled_bit  out  1  majority result, registered.
valid  out  1  one-cycle strobe: sampled_bit/noise updated.
noise  out  1  samples of the last completed bit were not unanimous.
cfg_err  out  1  current configuration is illegal; combinational from samp_num/Prescale.

Behaviour:
- Reset values: sampled_bit=0, valid=0, noise=0, sample register=0, capture counter=0, sync flops=1 (idle line).
- Let N=samp_num, H=Prescale>>1, S=H-(N>>1). Sample k (k=0..N-1) is captured when data_samp_en=1 and edge_cnt==S+k, taking rx_s (RX_IN after SYNC_STAGES flops).
- cfg_err=1 when any of these holds: N==0; N even; N>MAX_SAMPLES; H<(N>>1); S+N-1 >= Prescale. While cfg_err=1: no capture, capture counter held at 0, valid never asserts.
- Capture counter counts accepted samples. A sample is accepted only if edge_cnt==S+cnt (in-order). Compare arithmetic is done at PRESCALE_W+1 bits to avoid wrap.
- Completion: the cycle the N-th sample is accepted, register on the next edge:
  - sampled_bit = 1 if popcount(samples) > N>>1;
  - noise = 1 unless all N samples are equal;
  - valid = 1 for exactly one cycle.
  - Capture counter returns to 0.
  - Latency: valid high one CLK after edge_cnt==S+N-1.
- Abort: the counter clears to 0 with no valid, and sampled_bit/noise hold, in either case:
  - edge_cnt > S+cnt while 0 < cnt < N (missed edge);
  - data_samp_en falls mid-window.
- Outside completion: valid=0; sampled_bit and noise hold their last values.
- N=1: single sample at edge_cnt==H; noise is always 0.
- samp_num and Prescale are quasi-static: change only while data_samp_en=0. A change with enable high is treated as an abort if the sequence breaks.
- edge_cnt holding one value over several cycles: each sample index is accepted once only (the counter advances, so the next compare targets S+cnt).
- Reset mid-window: all state cleared asynchronously; the next window starts fresh.
- SYNC_STAGES>0 delays rx_s by that many cycles. The edge_cnt alignment is unchanged; the caller accounts for the delay.

Test Plan:
- Prescale=8, N=3, SYNC_STAGES=0, RX_IN=1,0,1 at edge_cnt 3,4,5 -> valid one cycle after edge_cnt=5; sampled_bit=1, noise=1.
- Prescale=16, N=5, RX_IN=0 at edges 6..10 -> sampled_bit=0, noise=0. Then a bit with RX_IN=1,1,0,0,1 -> sampled_bit=1, noise=1.
- Prescale=8, N=1, RX_IN=1 at edge 4 -> valid after edge 4, sampled_bit=1, noise=0. N=4 or N=0 -> cfg_err=1, no valid over a full bit.
- Prescale=4, N=5 (H=2, N>>1=2, S+N-1=4 >= 4) -> cfg_err=1, no capture. Prescale=6, N=5 -> cfg_err=0, samples at edges 1..5.
- Prescale=8, N=3: drop data_samp_en after edge 3, or jump edge_cnt 3->5 -> no valid, sampled_bit/noise unchanged; the next clean bit produces a correct valid.
- Assert RST low between edges 3 and 4 -> all outputs 0 immediately. Release and run a clean bit (1,1,1) -> valid with sampled_bit=1.

Source files
------------

// File: rtl/uart_rx_vote_sampler_if.sv
// Bus between the RX edge/bit counter + RX FSM (master) and the oversampling
// vote sampler (slave). Carries enable, serial line, counter position,
// configuration and the vote results.
interface uart_rx_vote_sampler_if #(
   parameter int PRESCALE_W  = 6,
   parameter int MAX_SAMPLES = 5
);
   localparam int CNT_W = $clog2(MAX_SAMPLES + 1);

   logic                  data_samp_en;
   logic                  RX_IN;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic [PRESCALE_W-1:0] Prescale;
   logic [CNT_W-1:0]      samp_num;
   logic                  sampled_bit;
   logic                  valid;
   logic                  noise;
   logic                  cfg_err;

   modport master (
      output data_samp_en, RX_IN, edge_cnt, Prescale, samp_num,
      input  sampled_bit, valid, noise, cfg_err
   );

   modport slave (
      input  data_samp_en, RX_IN, edge_cnt, Prescale, samp_num,
      output sampled_bit, valid, noise, cfg_err
   );
endinterface

// File: rtl/uart_rx_vote_sampler.sv
// Oversampling majority-vote sampler for the UART receiver.
// Captures an odd number of RX samples in a window centred on the middle of
// the bit period (edge_cnt == S+k, S = Prescale/2 - N/2), then registers the
// majority bit, a one-cycle valid strobe and a "samples disagreed" noise flag.
module uart_rx_vote_sampler #(
   parameter int PRESCALE_W  = 6,
   parameter int MAX_SAMPLES = 5,
   parameter int SYNC_STAGES = 0
) (
   input logic                   CLK,
   input logic                   RST,
   uart_rx_vote_sampler_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_SAMPLES + 1);
   // Window arithmetic runs one bit wider than its widest operand so that
   // S+cnt and S+N-1 never wrap back into the legal edge_cnt range.
   localparam int EXT_W = ((PRESCALE_W > CNT_W) ? PRESCALE_W : CNT_W) + 1;

   logic                   rx_s;
   logic [CNT_W-1:0]       cnt_q;
   logic [MAX_SAMPLES-1:0] samp_q;
   logic [MAX_SAMPLES-1:0] samp_next;
   logic                   bit_q;
   logic                   valid_q;
   logic                   noise_q;

   logic [EXT_W-1:0] n_x;
   logic [EXT_W-1:0] half_x;
   logic [EXT_W-1:0] h_x;
   logic [EXT_W-1:0] s_x;
   logic [EXT_W-1:0] last_x;
   logic [EXT_W-1:0] pre_x;
   logic [EXT_W-1:0] target_x;
   logic [EXT_W-1:0] edge_x;
   logic             cfg_err;
   logic             accept;
   logic             last_sample;
   logic             abort;
   logic [CNT_W-1:0] ones;
   logic             majority;
   logic             unanimous;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign rx_s = bus.RX_IN;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         // Synchroniser chain on the serial line, reset to the idle level (1)
         always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
               sync_q <= '1;
            end else begin
               sync_q <= (sync_q << 1) | SYNC_STAGES'(bus.RX_IN);
            end
         end
         assign rx_s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // Window position, configuration legality and the in-order accept/abort decision
   always_comb begin
      n_x      = EXT_W'(bus.samp_num);
      half_x   = n_x >> 1;
      h_x      = EXT_W'(bus.Prescale) >> 1;
      s_x      = h_x - half_x;
      last_x   = s_x + n_x - EXT_W'(1);
      pre_x    = EXT_W'(bus.Prescale);
      target_x = s_x + EXT_W'(cnt_q);
      edge_x   = EXT_W'(bus.edge_cnt);

      cfg_err = (bus.samp_num == '0) || !bus.samp_num[0] ||
                (n_x > EXT_W'(MAX_SAMPLES)) || (h_x < half_x) ||
                (last_x >= pre_x);

      accept      = bus.data_samp_en && !cfg_err && (edge_x == target_x);
      last_sample = accept && (cnt_q == bus.samp_num - CNT_W'(1));
      abort       = (cnt_q != '0) &&
                    (!bus.data_samp_en || cfg_err || (edge_x > target_x));
   end

   // Merge the sample being accepted this cycle and vote over the first N bits
   always_comb begin
      samp_next = samp_q;
      ones      = '0;
      for (int i = 0; i < MAX_SAMPLES; i++) begin
         if (accept && (CNT_W'(i) == cnt_q)) begin
            samp_next[i] = rx_s;
         end
      end
      for (int i = 0; i < MAX_SAMPLES; i++) begin
         if ((CNT_W'(i) < bus.samp_num) && samp_next[i]) begin
            ones = ones + CNT_W'(1);
         end
      end
      majority  = ones > (bus.samp_num >> 1);
      unanimous = (ones == '0) || (ones == bus.samp_num);
   end

   // Capture counter, sample store and registered vote results
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt_q   <= '0;
         samp_q  <= '0;
         bit_q   <= 1'b0;
         valid_q <= 1'b0;
         noise_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (accept) begin
            samp_q <= samp_next;
            if (last_sample) begin
               cnt_q   <= '0;
               bit_q   <= majority;
               noise_q <= !unanimous;
               valid_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end else if (abort) begin
            cnt_q <= '0;
         end
      end
   end

   assign bus.sampled_bit = bit_q;
   assign bus.valid       = valid_q;
   assign bus.noise       = noise_q;
   assign bus.cfg_err     = cfg_err;
endmodule

// File: tb/tb_uart_rx_vote_sampler.sv
// Directed bench for uart_rx_vote_sampler: a table of whole-bit vectors plus
// hand-written sequences for aborts, a held edge_cnt and a mid-window reset.
module tb_uart_rx_vote_sampler;
   localparam int PRESCALE_W  = 6;
   localparam int MAX_SAMPLES = 5;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   uart_rx_vote_sampler_if #(.PRESCALE_W(PRESCALE_W), .MAX_SAMPLES(MAX_SAMPLES)) bus();

   uart_rx_vote_sampler #(
      .PRESCALE_W (PRESCALE_W),
      .MAX_SAMPLES(MAX_SAMPLES),
      .SYNC_STAGES(0)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int         prescale;
      int         n;
      int         first;
      logic [4:0] rx;
      bit         expCfg;
      bit         expValid;
      bit         expBit;
      bit         expNoise;
   } vec_t;

   vec_t vecs[14];
   int   checks = 0;
   int   passes = 0;
   int   validCount;
   int   validAt;
   int   cycleIdx;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // One clock of stimulus: sample the strobe left by the previous edge, then drive
   task automatic applyStimulus(input bit en, input int edge_v, input bit rx);
      @(negedge CLK);
      if (bus.valid) begin
         validCount++;
         validAt = cycleIdx;
      end
      bus.data_samp_en = en;
      bus.edge_cnt     = PRESCALE_W'(edge_v);
      bus.RX_IN        = rx;
      cycleIdx++;
   endtask

   task automatic startBit(input int prescale, input int n);
      bus.Prescale = PRESCALE_W'(prescale);
      bus.samp_num = 3'(n);
      validCount   = 0;
      validAt      = -1;
      cycleIdx     = 0;
   endtask

   task automatic runRecord(input vec_t v, input string tag);
      bit r;
      startBit(v.prescale, v.n);
      #1;
      checkOutput({tag, " cfg_err"}, int'(bus.cfg_err), int'(v.expCfg));
      for (int c = 0; c <= v.prescale; c++) begin
         if (c == v.prescale) begin
            applyStimulus(1'b0, 0, 1'b0);
         end else begin
            if (c >= v.first && c < v.first + v.n) r = v.rx[c - v.first];
            else r = ~v.expBit;
            applyStimulus(1'b1, c, r);
         end
      end
      checkOutput({tag, " valid_count"}, validCount, v.expValid ? 1 : 0);
      if (v.expValid) checkOutput({tag, " valid_cycle"}, validAt, v.first + v.n);
      checkOutput({tag, " sampled_bit"}, int'(bus.sampled_bit), int'(v.expBit));
      checkOutput({tag, " noise"}, int'(bus.noise), int'(v.expNoise));
   endtask

   initial begin
      //           P   N  first rx        cfg val bit noise
      vecs[0]  = '{8,  3, 3, 5'b00101, 0, 1, 1, 1};
      vecs[1]  = '{16, 5, 6, 5'b00000, 0, 1, 0, 0};
      vecs[2]  = '{16, 5, 6, 5'b10011, 0, 1, 1, 1};
      vecs[3]  = '{8,  1, 4, 5'b00001, 0, 1, 1, 0};
      vecs[4]  = '{8,  4, 2, 5'b11111, 1, 0, 1, 0};
      vecs[5]  = '{8,  0, 2, 5'b11111, 1, 0, 1, 0};
      vecs[6]  = '{4,  5, 0, 5'b11111, 1, 0, 1, 0};
      vecs[7]  = '{6,  5, 1, 5'b00000, 0, 1, 0, 0};
      vecs[8]  = '{8,  3, 3, 5'b00110, 0, 1, 1, 1};
      vecs[9]  = '{16, 7, 5, 5'b11111, 1, 0, 1, 1};
      vecs[10] = '{8,  5, 2, 5'b00001, 0, 1, 0, 1};
      vecs[11] = '{2,  5, 0, 5'b00000, 1, 0, 0, 1};
      vecs[12] = '{3,  3, 0, 5'b00101, 0, 1, 1, 1};
      vecs[13] = '{8,  3, 3, 5'b00111, 0, 1, 1, 0};

      bus.data_samp_en = 1'b0;
      bus.RX_IN        = 1'b1;
      bus.edge_cnt     = '0;
      bus.Prescale     = PRESCALE_W'(8);
      bus.samp_num     = 3'd3;
      repeat (3) @(negedge CLK);
      checkOutput("reset valid", int'(bus.valid), 0);
      checkOutput("reset sampled_bit", int'(bus.sampled_bit), 0);
      checkOutput("reset noise", int'(bus.noise), 0);
      RST = 1'b1;
      @(negedge CLK);

      for (int i = 0; i < 14; i++) runRecord(vecs[i], $sformatf("vec%0d", i));

      // Abort: enable drops after the first sample; outputs hold at 1/0
      startBit(8, 3);
      for (int e = 0; e < 8; e++) applyStimulus(e <= 3, e, 1'b0);
      applyStimulus(1'b0, 0, 1'b0);
      checkOutput("en_drop valid_count", validCount, 0);
      checkOutput("en_drop sampled_bit", int'(bus.sampled_bit), 1);
      checkOutput("en_drop noise", int'(bus.noise), 0);
      runRecord('{8, 3, 3, 5'b00000, 0, 1, 0, 0}, "after_en_drop");

      // Abort: edge_cnt jumps 3 -> 5, so sample 1 is missed
      startBit(8, 3);
      for (int e = 0; e < 8; e++) if (e != 4) applyStimulus(1'b1, e, 1'b1);
      applyStimulus(1'b0, 0, 1'b0);
      checkOutput("jump valid_count", validCount, 0);
      checkOutput("jump sampled_bit", int'(bus.sampled_bit), 0);
      checkOutput("jump noise", int'(bus.noise), 0);
      runRecord('{8, 3, 3, 5'b00101, 0, 1, 1, 1}, "after_jump");

      // edge_cnt held at 3 for three cycles: only the first cycle is sample 0
      startBit(8, 3);
      applyStimulus(1'b1, 0, 1'b1);
      applyStimulus(1'b1, 1, 1'b1);
      applyStimulus(1'b1, 2, 1'b1);
      applyStimulus(1'b1, 3, 1'b0);
      applyStimulus(1'b1, 3, 1'b1);
      applyStimulus(1'b1, 3, 1'b1);
      applyStimulus(1'b1, 4, 1'b0);
      applyStimulus(1'b1, 5, 1'b0);
      applyStimulus(1'b1, 6, 1'b1);
      applyStimulus(1'b1, 7, 1'b1);
      applyStimulus(1'b0, 0, 1'b0);
      checkOutput("hold valid_count", validCount, 1);
      checkOutput("hold valid_cycle", validAt, 8);
      checkOutput("hold sampled_bit", int'(bus.sampled_bit), 0);
      checkOutput("hold noise", int'(bus.noise), 0);
      runRecord('{8, 3, 3, 5'b00011, 0, 1, 1, 1}, "after_hold");

      // Asynchronous reset between edges 3 and 4 of a window
      startBit(8, 3);
      for (int e = 0; e <= 3; e++) applyStimulus(1'b1, e, 1'b1);
      @(posedge CLK);
      #2;
      RST = 1'b0;
      #1;
      checkOutput("midreset valid", int'(bus.valid), 0);
      checkOutput("midreset sampled_bit", int'(bus.sampled_bit), 0);
      checkOutput("midreset noise", int'(bus.noise), 0);
      @(negedge CLK);
      bus.data_samp_en = 1'b0;
      RST = 1'b1;
      applyStimulus(1'b0, 0, 1'b0);
      runRecord('{8, 3, 3, 5'b00111, 0, 1, 1, 0}, "after_reset");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
